// File: rtl/seg7_scan_ctrl.sv
// Eight-digit seven-segment scan controller for the minips32 IO space.
// The CPU writes a 32-bit hex value (DATA) and a digit-enable / blank word (CTRL).
// The block then scans the eight digits at a fixed, constant duty cycle.
// Optional feature macro: SEG7_LEADING_ZERO_BLANK_EN. When it is defined, leading zero
// digits are blanked. Digit 0 is always shown.
module seg7_scan_ctrl #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        we_i,
  input  logic        addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic [7:0]  num_csn_o,
  output logic [6:0]  num_a_g_o
);

  localparam int unsigned CntW = $clog2(SCAN_DIV);
  localparam logic [CntW-1:0] CntMax = CntW'(SCAN_DIV - 1);

  localparam logic [8:0] CtrlRst = 9'h0FF;
  localparam logic [7:0] CsnOff  = 8'hFF;
  localparam logic [6:0] SegOff  = 7'h7F;

  // Hex to active-low segments, bit 6 = a ... bit 0 = g.
  function automatic logic [6:0] seg7_decode(input logic [3:0] nib);
    logic [6:0] seg;
    unique case (nib)
      4'h0:    seg = 7'b0000001;
      4'h1:    seg = 7'b1001111;
      4'h2:    seg = 7'b0010010;
      4'h3:    seg = 7'b0000110;
      4'h4:    seg = 7'b1001100;
      4'h5:    seg = 7'b0100100;
      4'h6:    seg = 7'b0100000;
      4'h7:    seg = 7'b0001111;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0000100;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b1100000;
      4'hC:    seg = 7'b0110001;
      4'hD:    seg = 7'b1000010;
      4'hE:    seg = 7'b0110000;
      default: seg = 7'b0111000;
    endcase
    return seg;
  endfunction

  logic [31:0]     data_q, data_d;
  logic [8:0]      ctrl_q, ctrl_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      csn_q, csn_d;
  logic [6:0]      seg_q, seg_d;

  logic [3:0] cur_nib;
  logic       suppress;
  logic       shown;

  // Register file next state: a write lands at the sampling edge, with no slot restart.
  always_comb begin
    data_d = data_q;
    ctrl_d = ctrl_q;
    if (we_i) begin
      if (addr_i) begin
        ctrl_d = wdata_i[8:0];
      end else begin
        data_d = wdata_i;
      end
    end
  end

  // Register file state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q <= '0;
      ctrl_q <= CtrlRst;
    end else begin
      data_q <= data_d;
      ctrl_q <= ctrl_d;
    end
  end

  // Combinational read-back. CTRL bits above 8 are not stored.
  always_comb begin
    rdata_o = addr_i ? {23'b0, ctrl_q} : data_q;
  end

  // Slot timer: cnt runs 0..SCAN_DIV-1, and idx advances (wrapping 7 to 0) on the terminal count.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    if (cnt_q == CntMax) begin
      cnt_d = '0;
      idx_d = idx_q + 3'd1;
    end
  end

  // Slot timer state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic [7:0] upper_zero;

  // upper_zero[i] is set when nibbles i..7 are all zero. This is evaluated live from DATA.
  always_comb begin
    upper_zero    = '0;
    upper_zero[7] = (data_q[31:28] == 4'h0);
    for (int i = 6; i >= 0; i--) begin
      upper_zero[i] = upper_zero[i+1] & (data_q[4*i +: 4] == 4'h0);
    end
    suppress = (idx_q != 3'd0) & upper_zero[idx_q];
  end
`else
  assign suppress = 1'b0;
`endif

  // Pin next state from the current slot. A hidden slot still uses its full time.
  always_comb begin
    cur_nib = data_q[{idx_q, 2'b00} +: 4];
    shown   = ctrl_q[idx_q] & ~ctrl_q[8] & ~suppress;
    csn_d   = CsnOff;
    seg_d   = SegOff;
    if (shown) begin
      csn_d = ~(8'h01 << idx_q);
      seg_d = seg7_decode(cur_nib);
    end
  end

  // Pin registers. Select and segments change on the same edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      csn_q <= CsnOff;
      seg_q <= SegOff;
    end else begin
      csn_q <= csn_d;
      seg_q <= seg_d;
    end
  end

  assign num_csn_o = csn_q;
  assign num_a_g_o = seg_q;

endmodule
